// File: rtl/game_pkg.sv
// Shared types and constants for the score/life game-rules stage.
//   game_state_t  : IDLE/PLAY/RESPAWN/GAME_OVER encoding seen on gameState
//   bcd_digit_t   : one BCD digit; bcd4_t : four-digit BCD score
//   hit_flags_t   : per-frame sticky collision flags
//   decToBcd8/12  : elaboration-time decimal to BCD conversion of point values
package game_pkg;

  localparam int unsigned SCORE_W = 16;
  localparam logic [SCORE_W-1:0] BCD_MAX = 16'h9999;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    RESPAWN   = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  typedef logic [3:0]         bcd_digit_t;
  typedef logic [SCORE_W-1:0] bcd4_t;

  typedef struct packed {
    logic good;
    logic bad;
    logic bumper;
    logic bottom;
  } hit_flags_t;

  // Three BCD digits, enough for the sum of two 0..99 point values.
  function automatic logic [11:0] decToBcd12(input int unsigned v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Two BCD digits for a 0..99 point value.
  function automatic logic [7:0] decToBcd8(input int unsigned v);
    logic [11:0] full;
    full = decToBcd12(v);
    return full[7:0];
  endfunction

endpackage

// File: rtl/bcd_addsub_sat.sv
// Combinational saturating BCD add/subtract of a small BCD delta to a 4-digit score.
//   operand  : 4-digit BCD input
//   delta    : DELTA_W/4-digit BCD amount
//   subtract : 0 = add (saturate at 9999), 1 = subtract (saturate at 0000)
//   result   : saturated 4-digit BCD output
module bcd_addsub_sat
  import game_pkg::*;
#(
  parameter int unsigned DELTA_W = 8
) (
  input  logic [SCORE_W-1:0] operand,
  input  logic [DELTA_W-1:0] delta,
  input  logic               subtract,
  output logic [SCORE_W-1:0] result
);

  logic [SCORE_W-1:0] deltaExt;
  logic [SCORE_W-1:0] raw;
  logic               carry;
  logic [4:0]         digitSum;

  assign deltaExt = SCORE_W'(delta);

  // Ripple digit by digit; carry doubles as borrow when subtracting.
  always_comb begin
    raw      = '0;
    carry    = 1'b0;
    digitSum = '0;
    for (int i = 0; i < 4; i++) begin
      if (subtract) begin
        digitSum = {1'b0, operand[4*i +: 4]} - {1'b0, deltaExt[4*i +: 4]} - {4'd0, carry};
        carry    = digitSum[4];
        if (carry) digitSum = digitSum + 5'd10;
      end else begin
        digitSum = {1'b0, operand[4*i +: 4]} + {1'b0, deltaExt[4*i +: 4]} + {4'd0, carry};
        carry    = (digitSum > 5'd9);
        if (carry) digitSum = digitSum - 5'd10;
      end
      raw[4*i +: 4] = digitSum[3:0];
    end
  end

  // A carry/borrow out of the thousands digit means the result left 0000..9999.
  assign result = !carry ? raw : (subtract ? '0 : BCD_MAX);

endmodule

// File: rtl/score_life_controller.sv
// Game-rules stage: accumulates per-frame collision events, commits score and
// lives once per frame on startOfFrame, and sequences play/respawn/game-over.
//   clk, resetN        : clock, synchronous active-low reset
//   startOfFrame       : frame boundary pulse, commit point
//   startGame          : start request honoured in IDLE and GAME_OVER
//   collisionBall*     : collision pulses from the detector
//   score              : 4-digit BCD score
//   lives              : remaining lives
//   gameState          : current game state
//   respawnBall        : one-cycle ball re-placement request
//   gameOver           : high while in GAME_OVER
module score_life_controller
  import game_pkg::*;
#(
  parameter int unsigned GOOD_PTS       = 10,
  parameter int unsigned BUMPER_PTS     = 5,
  parameter int unsigned BAD_PTS        = 20,
  parameter int unsigned INIT_LIVES     = 3,
  parameter int unsigned RESPAWN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        startGame,
  input  logic        collisionBallObstacleGood,
  input  logic        collisionBallObstacleBad,
  input  logic        collisionBallBumper,
  input  logic        collisionBallBottom,
  output bcd4_t       score,
  output logic [2:0]  lives,
  output game_state_t gameState,
  output logic        respawnBall,
  output logic        gameOver
);

  localparam logic [11:0] GOOD_BCD   = decToBcd12(GOOD_PTS);
  localparam logic [11:0] BUMPER_BCD = decToBcd12(BUMPER_PTS);
  localparam logic [11:0] BOTH_BCD   = decToBcd12(GOOD_PTS + BUMPER_PTS);
  localparam logic [7:0]  BAD_BCD    = decToBcd8(BAD_PTS);

  hit_flags_t flags;
  hit_flags_t hits;
  logic [7:0] respawnCnt;
  logic [11:0] addDelta;
  logic [7:0]  subDelta;
  bcd4_t      afterAdd;
  bcd4_t      afterSub;

  assign hits = '{good:   collisionBallObstacleGood,
                  bad:    collisionBallObstacleBad,
                  bumper: collisionBallBumper,
                  bottom: collisionBallBottom};

  // Good and bumper are merged into one step so the add saturates only once.
  always_comb begin
    addDelta = '0;
    case ({flags.good, flags.bumper})
      2'b10:   addDelta = GOOD_BCD;
      2'b01:   addDelta = BUMPER_BCD;
      2'b11:   addDelta = BOTH_BCD;
      default: addDelta = '0;
    endcase
    subDelta = flags.bad ? BAD_BCD : '0;
  end

  bcd_addsub_sat #(.DELTA_W(12)) uAdd (
    .operand  (score),
    .delta    (addDelta),
    .subtract (1'b0),
    .result   (afterAdd)
  );

  bcd_addsub_sat #(.DELTA_W(8)) uSub (
    .operand  (afterAdd),
    .delta    (subDelta),
    .subtract (1'b1),
    .result   (afterSub)
  );

  // Game state machine with registered outputs and per-frame commit.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      gameState   <= IDLE;
      score       <= '0;
      lives       <= '0;
      respawnBall <= 1'b0;
      gameOver    <= 1'b0;
      flags       <= '0;
      respawnCnt  <= '0;
    end else begin
      respawnBall <= 1'b0;
      case (gameState)
        IDLE, GAME_OVER: begin
          flags <= '0;
          if (startGame) begin
            gameState <= PLAY;
            score     <= '0;
            lives     <= 3'(INIT_LIVES);
            gameOver  <= 1'b0;
          end
        end
        PLAY: begin
          if (startOfFrame) begin
            score <= afterSub;
            // Coincident pulses belong to the new frame.
            flags <= hits;
            if (flags.bottom) begin
              lives <= lives - 3'd1;
              flags <= '0;
              if (lives == 3'd1) begin
                gameState <= GAME_OVER;
                gameOver  <= 1'b1;
              end else begin
                gameState   <= RESPAWN;
                respawnBall <= 1'b1;
                respawnCnt  <= 8'(RESPAWN_FRAMES);
              end
            end
          end else begin
            flags <= flags | hits;
          end
        end
        RESPAWN: begin
          flags <= '0;
          if (startOfFrame) begin
            respawnCnt <= respawnCnt - 8'd1;
            if (respawnCnt == 8'd1) gameState <= PLAY;
          end
        end
        default: gameState <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_life_controller.sv
// Directed self-checking bench for score_life_controller (default parameters).
module tb_score_life_controller;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic        startGame;
  logic        good;
  logic        bad;
  logic        bumper;
  logic        bottom;
  logic [15:0] score;
  logic [2:0]  lives;
  logic [1:0]  gameState;
  logic        respawnBall;
  logic        gameOver;

  int checks = 0;
  int errors = 0;

  score_life_controller dut (
    .clk                       (clk),
    .resetN                    (resetN),
    .startOfFrame              (startOfFrame),
    .startGame                 (startGame),
    .collisionBallObstacleGood (good),
    .collisionBallObstacleBad  (bad),
    .collisionBallBumper       (bumper),
    .collisionBallBottom       (bottom),
    .score                     (score),
    .lives                     (lives),
    .gameState                 (gameState),
    .respawnBall               (respawnBall),
    .gameOver                  (gameOver)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic s, input logic g, input logic b, input logic bp, input logic bt);
    startOfFrame = s; good = g; bad = b; bumper = bp; bottom = bt;
    @(posedge clk); #1;
    startOfFrame = 0; good = 0; bad = 0; bumper = 0; bottom = 0;
  endtask

  task automatic pressStart();
    startGame = 1'b1;
    @(posedge clk); #1;
    startGame = 1'b0;
  endtask

  task automatic checkAll(input string tag, input logic [15:0] s, input logic [2:0] l,
                          input logic [1:0] st, input logic rb, input logic go);
    checkVal({tag, "_score"}, 32'(score), 32'(s));
    checkVal({tag, "_lives"}, 32'(lives), 32'(l));
    checkVal({tag, "_state"}, 32'(gameState), 32'(st));
    checkVal({tag, "_respawn"}, 32'(respawnBall), 32'(rb));
    checkVal({tag, "_gameover"}, 32'(gameOver), 32'(go));
  endtask

  initial begin
    resetN = 0; startGame = 0;
    startOfFrame = 0; good = 0; bad = 0; bumper = 0; bottom = 0;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 16'h0000, 3'd0, 2'd0, 1'b0, 1'b0);
    resetN = 1;
    drive(1, 1, 0, 0, 0);
    checkAll("idle_ignores", 16'h0000, 3'd0, 2'd0, 1'b0, 1'b0);

    pressStart();
    checkAll("start", 16'h0000, 3'd3, 2'd1, 1'b0, 1'b0);

    // good+bumper, duplicate good, one commit
    drive(0, 1, 0, 1, 0);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    checkVal("good_bumper", 32'(score), 32'h0015);
    drive(1, 0, 0, 0, 0);
    checkVal("flags_cleared", 32'(score), 32'h0015);

    // bad from 15 saturates at zero
    drive(0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    checkVal("bad_sat15", 32'(score), 32'h0000);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    checkVal("good_10", 32'(score), 32'h0010);
    drive(0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    checkVal("bad_sat10", 32'(score), 32'h0000);
    // 0 + 15 + 10 = 25, then 25 - 20 = 5 (borrow across digits)
    drive(0, 1, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    checkVal("score_25", 32'(score), 32'h0025);
    drive(0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    checkVal("bad_borrow", 32'(score), 32'h0005);
    // all three in one frame: 5 + 15 - 20 = 0
    drive(0, 1, 1, 1, 0);
    drive(1, 0, 0, 0, 0);
    checkVal("all_three", 32'(score), 32'h0000);

    // climb to 9990 in steps of 15 from 0
    for (int i = 0; i < 666; i++) begin
      drive(0, 1, 0, 1, 0);
      drive(1, 0, 0, 0, 0);
    end
    checkVal("score_9990", 32'(score), 32'h9990);
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    checkVal("score_9995", 32'(score), 32'h9995);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    checkVal("add_sat", 32'(score), 32'h9999);
    drive(0, 1, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    checkVal("add_sat_hold", 32'(score), 32'h9999);
    drive(0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    checkVal("sub_9979", 32'(score), 32'h9979);

    // bottom plus good: score still commits, respawn begins
    drive(0, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    checkAll("respawn_enter", 16'h9989, 3'd2, 2'd2, 1'b1, 1'b0);
    drive(0, 0, 0, 0, 0);
    checkVal("respawn_pulse_1cyc", 32'(respawnBall), 32'h0);
    for (int i = 0; i < 59; i++) begin
      drive(0, 1, 1, 1, 1);
      drive(1, 1, 0, 0, 0);
    end
    checkAll("respawn_59", 16'h9989, 3'd2, 2'd2, 1'b0, 1'b0);
    drive(1, 1, 0, 0, 0);
    checkAll("respawn_done", 16'h9989, 3'd2, 2'd1, 1'b0, 1'b0);
    drive(1, 0, 0, 0, 0);
    checkVal("respawn_exit_ignored", 32'(score), 32'h9989);

    // pulse coincident with startOfFrame belongs to the next frame
    drive(1, 1, 0, 0, 0);
    checkVal("coincident_not_now", 32'(score), 32'h9989);
    drive(1, 0, 0, 0, 0);
    checkVal("coincident_next", 32'(score), 32'h9999);

    // lose second life
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    checkAll("life_1", 16'h9999, 3'd1, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) drive(1, 0, 0, 0, 0);
    checkVal("respawn2_done", 32'(gameState), 32'd1);

    // last life -> game over, no respawn pulse
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    checkAll("game_over", 16'h9999, 3'd0, 2'd3, 1'b0, 1'b1);
    drive(0, 0, 1, 1, 0);
    checkVal("go_no_respawn", 32'(respawnBall), 32'h0);
    drive(1, 0, 0, 0, 0);
    checkAll("go_frozen", 16'h9999, 3'd0, 2'd3, 1'b0, 1'b1);

    pressStart();
    checkAll("restart", 16'h0000, 3'd3, 2'd1, 1'b0, 1'b0);

    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    pressStart();
    checkAll("start_in_play", 16'h0010, 3'd3, 2'd1, 1'b0, 1'b0);

    // reset in the middle of a respawn
    drive(0, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    checkAll("respawn_again", 16'h0020, 3'd2, 2'd2, 1'b1, 1'b0);
    drive(1, 0, 0, 0, 0);
    resetN = 0;
    @(posedge clk); #1;
    checkAll("reset_mid", 16'h0000, 3'd0, 2'd0, 1'b0, 1'b0);
    resetN = 1;
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    checkAll("after_reset", 16'h0000, 3'd0, 2'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
